// File: rtl/por_pkg.sv
// Shared types and sizes for the POR trip-level scan sequencer.
// No logic; constants only.
// No flow control; consumed by por_trip_scan and its sub-blocks.
package por_pkg;

    localparam int TRIP_W         = 3;
    localparam int NUM_TRIP_CODES = 8;
    localparam int LEVEL_W        = 4;
    localparam int SETTLE_W       = 10;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } por_scan_state_e;

endpackage

// File: rtl/por_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the local clock.
// Latency: 2 clock edges from input change to output change.
// No backpressure; samples every cycle.
module por_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; both clear to 0 on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/por_trip_scan.sv
// Steps the POR trip code 0..7, samples the comparator at each, reports passing level.
// Latency: start at cycle 0 -> done at cycle 8*(SETTLE_CYCLES+2)+1.
// No backpressure: start while busy is dropped; abort returns to IDLE next cycle.
// Optional: define POR_TRIP_SCAN_PERIODIC_EN for automatic re-scan every PERIOD_CYCLES idle cycles.
module por_trip_scan
    import por_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int PERIOD_CYCLES = 65536
) (
    input  logic               osc_ck,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [TRIP_W-1:0]  otrip_cfg,
    input  logic               pwup_filt,
    output logic [TRIP_W-1:0]  otrip_out,
    output logic               scan_active,
    output logic               busy,
    output logic               done,
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid,
    output logic               nonmono_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TRIP_W-1:0]   LAST_CODE   = TRIP_W'(NUM_TRIP_CODES - 1);

    // Elaboration guard on parameter ranges.
    if (SETTLE_CYCLES < 4 || SETTLE_CYCLES > 1023 || PERIOD_CYCLES < 2) begin : g_bad_cfg
        $error("por_trip_scan: parameter out of range");
    end

    por_scan_state_e     r_state, w_state_nxt;
    logic [TRIP_W-1:0]   r_code, w_code_nxt;
    logic [SETTLE_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEVEL_W-1:0]  r_level_acc, w_level_acc_nxt;
    logic                r_first_fail, w_first_fail_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_scan_active, w_scan_active_nxt;
    logic                r_done, w_done_nxt;
    logic [LEVEL_W-1:0]  r_level, w_level_nxt;
    logic                r_level_valid, w_level_valid_nxt;
    logic                r_nonmono, w_nonmono_nxt;

    logic w_psync;
    logic w_start_any;

    por_sync2 u_psync (
        .i_clk (osc_ck),
        .i_rst (rst),
        .i_d   (pwup_filt),
        .o_q   (w_psync)
    );

`ifdef POR_TRIP_SCAN_PERIODIC_EN
    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

    logic [PW-1:0] r_per_cnt;
    logic          w_per_wrap;

    assign w_per_wrap = (r_state == IDLE) && (r_per_cnt == PW'(PERIOD_CYCLES - 1));

    // Idle-time counter; held at 0 while scanning so it restarts after FINISH or abort.
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
        end else if (r_state != IDLE || start || w_per_wrap) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
        end
    end

    assign w_start_any = start | w_per_wrap;
`else
    assign w_start_any = start;
`endif

    // State and datapath registers.
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_code        <= '0;
            r_cnt         <= '0;
            r_level_acc   <= '0;
            r_first_fail  <= 1'b0;
            r_busy        <= 1'b0;
            r_scan_active <= 1'b0;
            r_done        <= 1'b0;
            r_level       <= '0;
            r_level_valid <= 1'b0;
            r_nonmono     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_code        <= w_code_nxt;
            r_cnt         <= w_cnt_nxt;
            r_level_acc   <= w_level_acc_nxt;
            r_first_fail  <= w_first_fail_nxt;
            r_busy        <= w_busy_nxt;
            r_scan_active <= w_scan_active_nxt;
            r_done        <= w_done_nxt;
            r_level       <= w_level_nxt;
            r_level_valid <= w_level_valid_nxt;
            r_nonmono     <= w_nonmono_nxt;
        end
    end

    // Next-state and next-value logic; abort outside IDLE overrides all scan progress.
    always_comb begin
        w_state_nxt       = r_state;
        w_code_nxt        = r_code;
        w_cnt_nxt         = r_cnt;
        w_level_acc_nxt   = r_level_acc;
        w_first_fail_nxt  = r_first_fail;
        w_busy_nxt        = r_busy;
        w_scan_active_nxt = r_scan_active;
        w_done_nxt        = 1'b0;
        w_level_nxt       = r_level;
        w_level_valid_nxt = r_level_valid;
        w_nonmono_nxt     = r_nonmono;

        if (r_state != IDLE && abort) begin
            w_state_nxt       = IDLE;
            w_busy_nxt        = 1'b0;
            w_scan_active_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_any && !abort) begin
                        w_state_nxt       = APPLY;
                        w_code_nxt        = '0;
                        w_level_acc_nxt   = '0;
                        w_first_fail_nxt  = 1'b0;
                        w_nonmono_nxt     = 1'b0;
                        w_busy_nxt        = 1'b1;
                        w_scan_active_nxt = 1'b1;
                    end
                end
                APPLY: begin
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_state_nxt = SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = SAMPLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (w_psync && !r_first_fail) begin
                        w_level_acc_nxt = {1'b0, r_code} + 1'b1;
                    end
                    if (!w_psync) begin
                        w_first_fail_nxt = 1'b1;
                    end
                    if (w_psync && r_first_fail) begin
                        w_nonmono_nxt = 1'b1;
                    end
                    if (r_code == LAST_CODE) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_code_nxt  = r_code + 1'b1;
                        w_state_nxt = APPLY;
                    end
                end
                FINISH: begin
                    w_level_nxt       = r_level_acc;
                    w_level_valid_nxt = 1'b1;
                    w_done_nxt        = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_scan_active_nxt = 1'b0;
                    w_state_nxt       = IDLE;
                end
                default: begin
                    w_state_nxt       = IDLE;
                    w_busy_nxt        = 1'b0;
                    w_scan_active_nxt = 1'b0;
                end
            endcase
        end
    end

    // The functional code reaches the analog block whenever the scan does not own it,
    // including during reset.
    assign otrip_out   = r_scan_active ? r_code : otrip_cfg;
    assign scan_active = r_scan_active;
    assign busy        = r_busy;
    assign done        = r_done;
    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign nonmono_err = r_nonmono;

endmodule

// File: tb/tb_por_trip_scan.sv
// Self-checking bench for por_trip_scan with a short settle time.
// Expected results are queued at start and compared when done pulses.
// The comparator is modelled as a per-code pass/fail pattern.
module tb_por_trip_scan;

    localparam int SETTLE   = 8;
    localparam int EXP_DONE = 8 * (SETTLE + 2) + 1;

    logic       osc_ck;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] otrip_cfg;
    logic       pwup_filt;
    logic [2:0] otrip_out;
    logic       scan_active;
    logic       busy;
    logic       done;
    logic [3:0] level;
    logic       level_valid;
    logic       nonmono_err;

    typedef struct {
        logic [3:0] lvl;
        logic       nm;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] code_q[$];
    logic [7:0] r_pat;
    logic [3:0] last_lvl;
    logic       last_nm;
    int         n_cmp;
    int         n_bad;

    por_trip_scan #(
        .SETTLE_CYCLES (SETTLE),
        .PERIOD_CYCLES (200)
    ) dut (
        .osc_ck      (osc_ck),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .otrip_cfg   (otrip_cfg),
        .pwup_filt   (pwup_filt),
        .otrip_out   (otrip_out),
        .scan_active (scan_active),
        .busy        (busy),
        .done        (done),
        .level       (level),
        .level_valid (level_valid),
        .nonmono_err (nonmono_err)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    // Analog comparator model: pass/fail depends on the code currently applied.
    always @(negedge osc_ck) pwup_filt = r_pat[otrip_out];

    task automatic run_scan(input logic [7:0] pat, input int busy_start_cyc);
        exp_t       e;
        int         cyc;
        bit         got_done;
        logic [2:0] last_code;
        bit         first_seen;
        e.lvl = 4'd0;
        while (e.lvl < 4'd8 && pat[e.lvl[2:0]]) e.lvl = e.lvl + 4'd1;
        e.nm = 1'b0;
        for (int i = 0; i < 8; i++) if (pat[i] && i > int'(e.lvl)) e.nm = 1'b1;
        sb_q.push_back(e);
        for (int i = 0; i < 8; i++) code_q.push_back(3'(i));
        r_pat = pat;
        @(negedge osc_ck);
        start = 1'b1;
        @(posedge osc_ck);
        cyc = 0;
        got_done = 1'b0;
        first_seen = 1'b0;
        last_code = 3'd0;
        while (cyc < 200 && !got_done) begin
            @(negedge osc_ck);
            start = (cyc == busy_start_cyc);
            if (cyc == 40) otrip_cfg = 3'($urandom_range(0, 7));
            if (scan_active && (!first_seen || otrip_out !== last_code)) begin
                n_cmp++;
                if (code_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL code_step: extra code %0d, none expected", otrip_out);
                end else begin
                    logic [2:0] ec;
                    ec = code_q.pop_front();
                    if (otrip_out !== ec) begin
                        n_bad++;
                        $display("FAIL code_step: got %0d want %0d", otrip_out, ec);
                    end
                end
                first_seen = 1'b1;
                last_code = otrip_out;
            end
            if (done) begin
                got_done = 1'b1;
                e = sb_q.pop_front();
                n_cmp++;
                if (level !== e.lvl) begin
                    n_bad++;
                    $display("FAIL level: got %0d want %0d (pat %b)", level, e.lvl, pat);
                end
                n_cmp++;
                if (nonmono_err !== e.nm) begin
                    n_bad++;
                    $display("FAIL nonmono: got %0b want %0b (pat %b)", nonmono_err, e.nm, pat);
                end
                n_cmp++;
                if (cyc != EXP_DONE) begin
                    n_bad++;
                    $display("FAIL done_cycle: got %0d want %0d", cyc, EXP_DONE);
                end
                n_cmp++;
                if (level_valid !== 1'b1 || busy !== 1'b0 || scan_active !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_flags: lv=%0b busy=%0b act=%0b want 1 0 0", level_valid, busy, scan_active);
                end
                last_lvl = e.lvl;
                last_nm = e.nm;
            end
            @(posedge osc_ck);
            cyc++;
        end
        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL done_timeout: no done within 200 cycles, want cycle %0d", EXP_DONE);
            sb_q.delete();
        end
        @(negedge osc_ck);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || otrip_out !== otrip_cfg || code_q.size() != 0) begin
            n_bad++;
            $display("FAIL after_done: done=%0b busy=%0b out=%0d cfg=%0d codes_left=%0d",
                     done, busy, otrip_out, otrip_cfg, code_q.size());
        end
        code_q.delete();
    endtask

    task automatic test_reset();
        int i;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        otrip_cfg = 3'd5;
        r_pat = 8'hFF;
        repeat (2) @(negedge osc_ck);
        n_cmp++;
        if (otrip_out !== 3'd5 || busy !== 1'b0 || level !== 4'd0 || level_valid !== 1'b0 ||
            done !== 1'b0 || scan_active !== 1'b0 || nonmono_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: out=%0d busy=%0b lvl=%0d lv=%0b done=%0b act=%0b nm=%0b want 5 0 0 0 0 0 0",
                     otrip_out, busy, level, level_valid, done, scan_active, nonmono_err);
        end
        rst = 1'b0;
        @(negedge osc_ck);
        start = 1'b1;
        @(negedge osc_ck);
        start = 1'b0;
        for (i = 0; i < 200 && !(scan_active && otrip_out == 3'd3); i++) @(negedge osc_ck);
        n_cmp++;
        if (i >= 200) begin
            n_bad++;
            $display("FAIL reset_reach_code3: code 3 not reached, out=%0d", otrip_out);
        end
        repeat (4) @(negedge osc_ck);
        otrip_cfg = 3'd6;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (otrip_out !== 3'd6 || busy !== 1'b0 || scan_active !== 1'b0 || done !== 1'b0 ||
            level !== 4'd0 || level_valid !== 1'b0 || nonmono_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midscan: out=%0d busy=%0b act=%0b done=%0b lvl=%0d lv=%0b nm=%0b want 6 0 0 0 0 0 0",
                     otrip_out, busy, scan_active, done, level, level_valid, nonmono_err);
        end
        @(negedge osc_ck);
        rst = 1'b0;
        @(negedge osc_ck);
    endtask

    task automatic test_monotonic();
        otrip_cfg = 3'd2;
        run_scan(8'b0001_1111, -1);
    endtask

    task automatic test_all_high();
        run_scan(8'hFF, -1);
    endtask

    task automatic test_all_low();
        run_scan(8'h00, -1);
    endtask

    task automatic test_nonmono();
        run_scan(8'b0000_1011, -1);
    endtask

    task automatic test_start_while_busy();
        run_scan(8'b0000_0111, 30);
    endtask

    task automatic test_abort();
        int i;
        int n_done;
        run_scan(8'b0001_1111, -1);
        otrip_cfg = 3'd1;
        @(negedge osc_ck);
        start = 1'b1;
        @(negedge osc_ck);
        start = 1'b0;
        for (i = 0; i < 200 && !(scan_active && otrip_out == 3'd4); i++) @(negedge osc_ck);
        n_cmp++;
        if (i >= 200) begin
            n_bad++;
            $display("FAIL abort_reach_code4: code 4 not reached, out=%0d", otrip_out);
        end
        abort = 1'b1;
        n_done = 0;
        @(negedge osc_ck);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || scan_active !== 1'b0 || otrip_out !== 3'd1) begin
            n_bad++;
            $display("FAIL abort_exit: busy=%0b act=%0b out=%0d want 0 0 1", busy, scan_active, otrip_out);
        end
        for (int k = 0; k < 100; k++) begin
            if (done) n_done++;
            @(negedge osc_ck);
        end
        n_cmp++;
        if (n_done != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", n_done);
        end
        n_cmp++;
        if (level !== last_lvl || level_valid !== 1'b1 || nonmono_err !== last_nm) begin
            n_bad++;
            $display("FAIL abort_hold: lvl=%0d lv=%0b nm=%0b want %0d 1 %0b",
                     level, level_valid, nonmono_err, last_lvl, last_nm);
        end
    endtask

    task automatic test_start_abort_idle();
        int n_act;
        start = 1'b1;
        abort = 1'b1;
        @(negedge osc_ck);
        start = 1'b0;
        abort = 1'b0;
        n_act = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || scan_active || done) n_act++;
            @(negedge osc_ck);
        end
        n_cmp++;
        if (n_act != 0) begin
            n_bad++;
            $display("FAIL start_abort_idle: active cycles=%0d want 0", n_act);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_lvl = 4'd0;
        last_nm = 1'b0;
        test_reset();
        test_monotonic();
        test_all_high();
        test_all_low();
        test_nonmono();
        test_start_while_busy();
        test_abort();
        test_start_abort_idle();
        test_all_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
